// File: rtl/exception_unit.sv
// exception_unit: precise-exception tracker for a 5-stage pipeline.
// Carries one exception record per stage (ID, EX, MEM), resolves the oldest
// cause at MEM, pulses the CP0 exception/return strobes, flushes the pipe and
// holds a redirect request until fetch accepts it.
// Optional feature: define EXCEPTION_UNIT_INT_EN to let the external interrupt
// commit (code 0) at a valid MEM record; without it the interrupt is ignored.
// The eret strobe is named return_o because "return" is a reserved word.
module exception_unit (
  input  logic        clk,
  input  logic        rstn,
  // pipeline side
  input  logic        pipe_adv,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic        id_bp,
  input  logic        id_eret,
  input  logic        id_in_ds,
  input  logic        ex_ov,
  input  logic        mem_ade_l,
  input  logic        mem_ade_s,
  input  logic [31:0] mem_vaddr,
  // CP0 side
  input  logic        interupt,
  input  logic        cp0_status_exl,
  input  logic [31:0] return_addr,
  output logic        execption,
  output logic        return_o,
  output logic [4:0]  exc_code,
  output logic [31:0] cp0_epc,
  output logic        cp0_status_bd,
  output logic [31:0] cp0_badvaddr,
  // control
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;
  localparam logic [4:0]  EXC_SYS  = 5'd8;
  localparam logic [4:0]  EXC_BP   = 5'd9;
  localparam logic [4:0]  EXC_RI   = 5'd10;
  localparam logic [4:0]  EXC_OV   = 5'd12;
  localparam logic [31:0] EXC_VEC  = 32'hBFC00380;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic        has_exc;
    logic [4:0]  code;
    logic [31:0] badvaddr;
    logic        eret;
  } rec_t;

  typedef enum logic {IDLE, REDIRECT} state_t;

  rec_t   id_q, ex_q, mem_q;
  rec_t   id_d, ex_d, mem_d;
  rec_t   mem_c;          // MEM record with MEM-stage causes folded in
  state_t state_q, state_d;
  logic [31:0] redir_q, redir_d;
  logic   irq_req;
  logic   take_exc, take_eret, kill;

`ifdef EXCEPTION_UNIT_INT_EN
  assign irq_req = interupt & ~cp0_status_exl;
`else
  logic unused_irq;
  assign irq_req    = 1'b0;
  assign unused_irq = interupt ^ cp0_status_exl;
`endif

  // ID record built from fetch: misaligned fetch PC is the earliest cause
  always_comb begin
    id_d       = '0;
    id_d.valid = if_valid;
    id_d.pc    = if_pc;
    if (if_valid && (if_pc[1:0] != 2'b00)) begin
      id_d.has_exc  = 1'b1;
      id_d.code     = EXC_ADEL;
      id_d.badvaddr = if_pc;
    end
  end

  // ID -> EX: attach decode info; decode causes only if nothing older exists
  always_comb begin
    ex_d = id_q;
    if (id_q.valid) begin
      ex_d.bd   = id_in_ds;
      ex_d.eret = id_eret;
      if (!id_q.has_exc) begin
        if (id_ri) begin
          ex_d.has_exc = 1'b1;
          ex_d.code    = EXC_RI;
        end else if (id_sys) begin
          ex_d.has_exc = 1'b1;
          ex_d.code    = EXC_SYS;
        end else if (id_bp) begin
          ex_d.has_exc = 1'b1;
          ex_d.code    = EXC_BP;
        end
      end
    end
  end

  // EX -> MEM: overflow only if no older cause
  always_comb begin
    mem_d = ex_q;
    if (ex_q.valid && !ex_q.has_exc && ex_ov) begin
      mem_d.has_exc = 1'b1;
      mem_d.code    = EXC_OV;
    end
  end

  // MEM-stage address errors resolved in the commit cycle itself
  always_comb begin
    mem_c = mem_q;
    if (mem_q.valid && !mem_q.has_exc) begin
      if (mem_ade_l) begin
        mem_c.has_exc  = 1'b1;
        mem_c.code     = EXC_ADEL;
        mem_c.badvaddr = mem_vaddr;
      end else if (mem_ade_s) begin
        mem_c.has_exc  = 1'b1;
        mem_c.code     = EXC_ADES;
        mem_c.badvaddr = mem_vaddr;
      end
    end
  end

  assign take_exc  = (state_q == IDLE) && mem_q.valid && (mem_c.has_exc || irq_req);
  assign take_eret = (state_q == IDLE) && mem_q.valid && mem_q.eret && !take_exc;
  assign kill      = (state_q == REDIRECT) || take_exc || take_eret;

  // Stage records: wiped on any flush, shifted on pipe_adv, held otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_q  <= '0;
      ex_q  <= '0;
      mem_q <= '0;
    end else if (kill) begin
      id_q  <= '0;
      ex_q  <= '0;
      mem_q <= '0;
    end else if (pipe_adv) begin
      id_q  <= id_d;
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  // FSM state and latched redirect target
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
    end
  end

  // Next state and outputs; commit strobes are Mealy so they last one cycle
  always_comb begin
    state_d        = state_q;
    redir_d        = redir_q;
    execption      = 1'b0;
    return_o       = 1'b0;
    exc_code       = '0;
    cp0_epc        = '0;
    cp0_status_bd  = 1'b0;
    cp0_badvaddr   = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        if (take_exc) begin
          execption     = 1'b1;
          flush         = 1'b1;
          exc_code      = irq_req ? EXC_INT : mem_c.code;
          cp0_epc       = mem_q.bd ? (mem_q.pc - 32'd4) : mem_q.pc;
          cp0_status_bd = mem_q.bd;
          cp0_badvaddr  = mem_c.badvaddr;
          redir_d       = EXC_VEC;
          state_d       = REDIRECT;
        end else if (take_eret) begin
          return_o = 1'b1;
          flush    = 1'b1;
          redir_d  = return_addr;
          state_d  = REDIRECT;
        end
      end
      REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = redir_q;
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; rstn  in  1  asynchronous active-low reset.
REQ-002 SHALL have pipeline inputs: pipe_adv in 1 global stage advance; if_valid in 1; if_pc in 32; id_ri in 1 reserved instr; id_sys in 1; id_bp in 1; id_eret in 1; id_in_ds in 1 delay-slot flag; ex_ov in 1 overflow; mem_ade_l in 1 load addr error; mem_ade_s in 1 store addr error; mem_vaddr in 32 data address.
REQ-003 SHALL have CP0-side inputs: interupt in 1; cp0_status_exl in 1; return_addr in 32 (EPC readback).
REQ-004 SHALL have CP0-side outputs: execption out 1; return out 1; exc_code out 5; cp0_epc out 32; cp0_status_bd out 1; cp0_badvaddr out 32.
REQ-005 SHALL have control outputs: flush out 1 kill IF..MEM; redirect_valid out 1; redirect_pc out 32; redirect_ready in 1 from fetch.

Function
REQ-006 SHALL carry one record per stage (ID, EX, MEM) {valid, pc, bd, has_exc, code, badvaddr, eret}, shifted one stage per clk when pipe_adv=1, held otherwise.
REQ-007 SHALL load the ID record from IF inputs; if_pc[1:0]!=0 with if_valid=1 records code 4 (AdEL), badvaddr=if_pc.
REQ-008 SHALL, at each stage, keep an existing earlier exception and only add a later-stage cause if has_exc=0 (oldest cause wins).
REQ-009 SHALL apply ID causes in priority RI(10) > Sys(8) > Bp(9); EX cause Ov(12); MEM causes AdEL(4)/AdES(5) with badvaddr=mem_vaddr.
REQ-010 SHALL commit at the MEM record when valid; interrupt (code 0) overrides all causes when interupt=1 and cp0_status_exl=0.
REQ-011 FSM states: IDLE, REDIRECT; reset state IDLE.
REQ-012 In IDLE, on committed exception: execption=1 for exactly that cycle, flush=1, exc_code per REQ-009/010, cp0_epc = bd ? pc-4 : pc, cp0_status_bd=bd, cp0_badvaddr from record; next state REDIRECT with redirect_pc=32'hBFC00380.
REQ-013 In IDLE, on committed eret without exception: return=1 for one cycle, flush=1, redirect_pc=return_addr sampled that cycle; next state REDIRECT.
REQ-014 Exception and eret on same record: exception wins, return stays 0.
REQ-015 In REDIRECT: redirect_valid=1, redirect_pc stable, flush=1, all records invalidated, no new commits; leave to IDLE the cycle after redirect_valid&&redirect_ready.
REQ-016 redirect_ready=1 on REDIRECT entry cycle is not sampled; earliest exit is one cycle after entry.
REQ-017 execption and return SHALL never both be 1; each is a single-cycle pulse.
REQ-018 pc-4 SHALL wrap modulo 2^32 (pc=0 gives 32'hFFFFFFFC).
REQ-019 cp0_epc, cp0_status_bd, cp0_badvaddr, exc_code SHALL be zero when execption=0.

Reset
REQ-020 rstn=0 SHALL immediately clear all records, FSM to IDLE, all outputs 0, including mid-REDIRECT.
REQ-021 First commit possible no earlier than the third pipe_adv after rstn release.

Configuration
REQ-022 Macro EXCEPTION_UNIT_INT_EN: defined -> interrupt commit per REQ-010; undefined -> interupt input ignored, code 0 never produced, all else unchanged.

Verification
REQ-023 if_pc=32'h00400002, three pipe_adv -> execption=1, exc_code=4, cp0_badvaddr=32'h00400002, cp0_epc=32'h00400002, redirect_pc=32'hBFC00380.
REQ-024 id_ri=1 and ex_ov=1 on later stage for same record, pc=32'h00400010, id_in_ds=1 -> exc_code=10, cp0_epc=32'h0040000C, cp0_status_bd=1.
REQ-025 id_eret=1, return_addr=32'h00400100 -> return=1 one cycle, redirect_pc=32'h00400100; redirect_ready held 0 five cycles -> redirect_valid stays 1, flush stays 1.
REQ-026 interupt=1, cp0_status_exl=0, valid MEM record with mem_ade_s=1 -> exc_code=0 (macro defined) / 5 (undefined); with cp0_status_exl=1 -> 5.
REQ-027 rstn pulled low in REDIRECT -> redirect_valid, flush, execption 0 immediately; no pulse after release.
